// File: rtl/conv_window_sequencer_if.sv
// conv_window_sequencer_if: config/start/stall inputs and tap/output-write signals of the window sequencer
// master drives cfg_we, cfg_in ([4:0]=N [8:5]=K [11:9]=S), start, stall;
// slave drives busy, done, cfg_err, rd_addr, k_addr, mac_en, acc_clr, acc_last, out_wr, out_addr
interface conv_window_sequencer_if #(
  parameter int ADDR_W  = 10,
  parameter int KADDR_W = 8
);
  logic               cfg_we;
  logic [11:0]        cfg_in;
  logic               start;
  logic               stall;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [ADDR_W-1:0]  rd_addr;
  logic [KADDR_W-1:0] k_addr;
  logic               mac_en;
  logic               acc_clr;
  logic               acc_last;
  logic               out_wr;
  logic [ADDR_W-1:0]  out_addr;
  modport master (
    output cfg_we, cfg_in, start, stall,
    input  busy, done, cfg_err, rd_addr, k_addr, mac_en, acc_clr, acc_last, out_wr, out_addr
  );
  modport slave (
    input  cfg_we, cfg_in, start, stall,
    output busy, done, cfg_err, rd_addr, k_addr, mac_en, acc_clr, acc_last, out_wr, out_addr
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks KxK windows of an NxN input at stride S, one MAC tap per cycle, then writes each pixel
// clk, rst_n (async, active-low); bus: conv_window_sequencer_if.slave carrying config, start, stall,
// status (busy/done/cfg_err), tap controls (rd_addr/k_addr/mac_en/acc_clr/acc_last) and output writes
module conv_window_sequencer #(
  parameter int DIM_W   = 5,
  parameter int KDIM_W  = 4,
  parameter int STR_W   = 3,
  parameter int ADDR_W  = 10,
  parameter int KADDR_W = 8,
  parameter int MAC_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  conv_window_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [DIM_W-1:0] n, o, ox, oy;
  logic [KDIM_W-1:0] k, r, c;
  logic [STR_W-1:0] s;
  logic [2:0] dcnt;
  logic err_q;
  logic [ADDR_W-1:0] rd_hold, pix;
  logic [KADDR_W-1:0] k_hold;
  logic dl_v [MAC_LAT];
  logic [ADDR_W-1:0] dl_p [MAC_LAT];
  logic legal, flow, tap, shift, last_c, last_r, last_x, last_y;
  logic [31:0] o_calc, rd_calc, k_calc;
  assign legal = n != '0 && k != '0 && s != '0 && 32'(k) <= 32'(n)
              && 32'(n) * 32'(n) <= (32'd1 << ADDR_W);
  // divisor guarded so an illegal S=0 config never produces X; o is unused in that case
  assign o_calc = (32'(n) - 32'(k)) / (s == '0 ? 32'd1 : 32'(s)) + 32'd1;
  assign flow = !bus.stall;
  assign tap = state == RUN && flow;
  assign shift = (state == RUN || state == DRAIN) && flow;
  assign last_c = c == k - KDIM_W'(1);
  assign last_r = r == k - KDIM_W'(1);
  assign last_x = ox == o - DIM_W'(1);
  assign last_y = oy == o - DIM_W'(1);
  assign rd_calc = (32'(oy) * 32'(s) + 32'(r)) * 32'(n) + 32'(ox) * 32'(s) + 32'(c);
  assign k_calc = 32'(r) * 32'(k) + 32'(c);
  assign pix = ADDR_W'(32'(oy) * 32'(o) + 32'(ox));
  assign bus.busy = state == CHECK || state == RUN || state == DRAIN;
  assign bus.done = state == DONE;
  assign bus.cfg_err = err_q;
  assign bus.mac_en = tap;
  assign bus.acc_clr = tap && c == '0 && r == '0;
  assign bus.acc_last = tap && last_c && last_r;
  // addresses keep showing the last issued tap whenever no tap is issued
  assign bus.rd_addr = tap ? ADDR_W'(rd_calc) : rd_hold;
  assign bus.k_addr = tap ? KADDR_W'(k_calc) : k_hold;
  assign bus.out_wr = dl_v[MAC_LAT-1] && flow;
  assign bus.out_addr = dl_p[MAC_LAT-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? CHECK : IDLE;
      CHECK:   state_nx = legal ? RUN : DONE;
      RUN:     state_nx = tap && last_c && last_r && last_x && last_y ? DRAIN : RUN;
      DRAIN:   state_nx = flow && dcnt == 3'(MAC_LAT - 1) ? DONE : DRAIN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {s, k, n} <= '0;
      o <= '0;
      {ox, oy, r, c} <= '0;
      dcnt <= '0;
      err_q <= 1'b0;
      rd_hold <= '0;
      k_hold <= '0;
    end else begin
      if (state == IDLE && bus.cfg_we) {s, k, n} <= bus.cfg_in;
      if (state == IDLE && bus.start) begin
        {ox, oy, r, c} <= '0;
        err_q <= 1'b0;
      end
      if (state == CHECK) begin
        o <= DIM_W'(o_calc);
        err_q <= !legal;
      end
      if (tap) begin
        c <= last_c ? '0 : c + KDIM_W'(1);
        if (last_c) r <= last_r ? '0 : r + KDIM_W'(1);
        if (last_c && last_r) ox <= last_x ? '0 : ox + DIM_W'(1);
        if (last_c && last_r && last_x) oy <= last_y ? '0 : oy + DIM_W'(1);
        rd_hold <= ADDR_W'(rd_calc);
        k_hold <= KADDR_W'(k_calc);
      end
      dcnt <= tap ? '0 : state == DRAIN && flow ? dcnt + 3'd1 : dcnt;
    end
  // (acc_last, pixel) delay line aligning output writes with the MAC result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        dl_v[i] <= 1'b0;
        dl_p[i] <= '0;
      end
    end else if (shift) begin
      dl_v[0] <= tap && last_c && last_r;
      dl_p[0] <= pix;
      for (int i = 1; i < MAC_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_p[i] <= dl_p[i-1];
      end
    end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: scoreboard bench with directed and randomized passes against a loop-based reference model
module tb_conv_window_sequencer;
  localparam int ADDR_W = 10, KADDR_W = 8, MAC_LAT = 1;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [KADDR_W-1:0] ka;
    logic clr;
    logic last;
  } tap_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  conv_window_sequencer_if #(.ADDR_W(ADDR_W), .KADDR_W(KADDR_W)) bus();
  conv_window_sequencer #(.ADDR_W(ADDR_W), .KADDR_W(KADDR_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  tap_t tap_q[$];
  logic [ADDR_W-1:0] out_q[$];
  int done_q[$];
  int stall_pts[$];
  logic [ADDR_W-1:0] obs_rd[$];
  int checks = 0, passed = 0, cyc = 0;
  tap_t exp_tap;
  logic [ADDR_W-1:0] exp_out;
  int exp_done;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  // reference: enumerate output pixels row-major, each window row-major
  task automatic model(input int n, input int k, input int s, output bit ok, output int len);
    int o;
    ok = n > 0 && k > 0 && s > 0 && k <= n && n * n <= (1 << ADDR_W);
    len = 0;
    if (!ok) return;
    o = (n - k) / s + 1;
    for (int py = 0; py < o; py++)
      for (int px = 0; px < o; px++) begin
        for (int wr = 0; wr < k; wr++)
          for (int wc = 0; wc < k; wc++)
            tap_q.push_back('{rd: ADDR_W'((py * s + wr) * n + px * s + wc), ka: KADDR_W'(wr * k + wc),
                              clr: wr == 0 && wc == 0, last: wr == k - 1 && wc == k - 1});
        out_q.push_back(ADDR_W'(py * o + px));
      end
    len = k * k * o * o;
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (bus.mac_en) begin
        obs_rd.push_back(bus.rd_addr);
        if (tap_q.size() == 0) begin
          checks++;
          $display("FAIL tap: unexpected tap rd_addr=%0d at cycle %0d", bus.rd_addr, cyc);
        end else begin
          exp_tap = tap_q.pop_front();
          check("tap", {bus.rd_addr, bus.k_addr, bus.acc_clr, bus.acc_last}, exp_tap);
        end
      end
      if (bus.out_wr) begin
        if (out_q.size() == 0) begin
          checks++;
          $display("FAIL out_wr: unexpected write out_addr=%0d at cycle %0d", bus.out_addr, cyc);
        end else begin
          exp_out = out_q.pop_front();
          check("out_addr", bus.out_addr, exp_out);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          checks++;
          $display("FAIL done: unexpected done at cycle %0d", cyc);
        end else begin
          exp_done = done_q.pop_front();
          check("done_cycle", cyc, exp_done);
        end
      end
      if (bus.stall) check("stall_gate", {bus.mac_en, bus.out_wr}, 0);
    end
  task automatic run_pass(input int n, input int k, input int s, input int pct, input bit noise, input int abort_at);
    int len, ns, hold;
    bit ok;
    @(posedge clk); #1;
    bus.cfg_we = 1'b1;
    bus.cfg_in = {3'(s), 4'(k), 5'(n)};
    bus.start = 1'b1;
    model(n, k, s, ok, len);
    if (!ok) done_q.push_back(cyc + 2);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    bus.start = 1'b0;
    if (ok) begin
      ns = 0;
      hold = 0;
      while (ns < len + MAC_LAT) begin
        @(posedge clk); #1;
        if (hold > 0) begin
          bus.stall = 1'b1;
          hold--;
        end else if (stall_pts.size() > 0 && stall_pts[0] == ns) begin
          void'(stall_pts.pop_front());
          bus.stall = 1'b1;
          hold = 2;
        end else bus.stall = $urandom_range(99) < pct;
        // start/cfg_we while busy must have no effect
        bus.start = noise && $urandom_range(3) == 0;
        bus.cfg_we = noise && $urandom_range(3) == 0;
        bus.cfg_in = 12'($urandom);
        if (!bus.stall) begin
          if (ns == abort_at) begin
            @(negedge clk);
            #2 rst_n = 1'b0;
            tap_q.delete();
            out_q.delete();
            done_q.delete();
            @(negedge clk);
            check("reset_mid_pass", {bus.busy, bus.done, bus.cfg_err, bus.mac_en, bus.acc_clr, bus.acc_last,
                                     bus.out_wr, bus.rd_addr, bus.k_addr, bus.out_addr}, 0);
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.cfg_we = 1'b0;
            rst_n = 1'b1;
            return;
          end
          ns++;
        end
      end
      done_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    bus.stall = 1'b0;
    bus.start = 1'b0;
    bus.cfg_we = 1'b0;
    @(posedge clk); #1;
    check("pass_drained", tap_q.size() + out_q.size() + done_q.size(), 0);
    check("cfg_err", {bus.cfg_err, bus.busy}, {!ok, 1'b0});
  endtask
  initial begin
    int win[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int px0[4] = '{0, 2, 10, 12};
    int n, k, s;
    bus.cfg_we = 1'b0;
    bus.cfg_in = '0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {bus.busy, bus.done, bus.cfg_err, bus.mac_en, bus.acc_clr, bus.acc_last,
                          bus.out_wr, bus.rd_addr, bus.k_addr, bus.out_addr}, 0);
    #2 rst_n = 1'b1;
    obs_rd.delete();
    run_pass(5, 3, 1, 0, 1'b0, -1);
    for (int i = 0; i < 9; i++) check("case1_rd", obs_rd.size() > i ? obs_rd[i] : 'x, win[i]);
    obs_rd.delete();
    run_pass(5, 3, 2, 0, 1'b0, -1);
    for (int i = 0; i < 4; i++) check("case2_rd", obs_rd.size() > 9 * i ? obs_rd[9 * i] : 'x, px0[i]);
    obs_rd.delete();
    run_pass(5, 3, 3, 0, 1'b0, -1);
    check("case3_taps", obs_rd.size(), 9);
    for (int i = 0; i < 9; i++) check("case3_rd", obs_rd.size() > i ? obs_rd[i] : 'x, win[i]);
    run_pass(5, 6, 1, 0, 1'b0, -1);
    run_pass(5, 3, 1, 0, 1'b0, -1);
    stall_pts = '{10, 36};
    run_pass(5, 3, 1, 0, 1'b0, -1);
    check("case5_stall_pts_used", stall_pts.size(), 0);
    run_pass(5, 3, 1, 0, 1'b0, 40);
    obs_rd.delete();
    run_pass(5, 3, 1, 0, 1'b0, -1);
    check("restart_taps", obs_rd.size(), 81);
    run_pass(4, 4, 1, 0, 1'b0, -1);
    run_pass(6, 1, 2, 0, 1'b0, -1);
    run_pass(0, 1, 1, 0, 1'b0, -1);
    run_pass(5, 0, 1, 0, 1'b0, -1);
    run_pass(5, 2, 0, 0, 1'b0, -1);
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(1, 12);
      k = $urandom_range(1, n);
      s = $urandom_range(1, 7);
      if ($urandom_range(9) == 0) k = $urandom_range(0, 15);
      if ($urandom_range(9) == 0) s = 0;
      run_pass(n, k, s, $urandom_range(0, 40), 1'b1, -1);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
